// File: rtl/serial_paralelo_rx_pkg.sv
// Shared PHY lane definitions: symbol width, comma/idle symbol and the
// receive alignment state encoding used by the deserializer.
package serial_paralelo_rx_pkg;

    localparam int SYMBOL_WIDTH = 8;
    localparam logic [SYMBOL_WIDTH-1:0] COMMA_SYMBOL = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: slides a window over the serial line until a comma is
// seen, confirms byte alignment on consecutive commas, then emits bytes.
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter int                WIDTH      = SYMBOL_WIDTH,
    parameter logic [WIDTH-1:0]  COMMA      = COMMA_SYMBOL,
    parameter int                LOCK_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             byte_strobe,
    output logic             active
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  LOCK_MAX = BC_W'(LOCK_COUNT);

    // Only the previous WIDTH-1 bits are stored; the incoming bit completes the window.
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_next, bit_cnt_wrap;
    logic [BC_W-1:0]  bc_cnt, bc_cnt_next, bc_cnt_inc;
    rx_state_t        state, state_next;
    logic [WIDTH-1:0] data_next;
    logic             valid_next;
    logic             strobe_next;
    logic             active_next;
    logic             byte_done;
    logic             is_comma;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr          <= '0;
            bit_cnt     <= '0;
            bc_cnt      <= '0;
            state       <= SEARCH;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr          <= sr_next[WIDTH-2:0];
            bit_cnt     <= bit_cnt_next;
            bc_cnt      <= bc_cnt_next;
            state       <= state_next;
            data_out    <= data_next;
            valid_out   <= valid_next;
            byte_strobe <= strobe_next;
            active      <= active_next;
        end
    end

    always_comb begin
        sr_next      = {sr, data_in};
        is_comma     = (sr_next == COMMA);
        byte_done    = (bit_cnt == LAST_BIT);
        bit_cnt_wrap = byte_done ? '0 : bit_cnt + 1'b1;
        bc_cnt_inc   = (bc_cnt == LOCK_MAX) ? LOCK_MAX : bc_cnt + 1'b1;

        state_next   = state;
        bit_cnt_next = bit_cnt;
        bc_cnt_next  = bc_cnt;
        data_next    = data_out;
        valid_next   = valid_out;
        strobe_next  = 1'b0;
        active_next  = active;

        case (state)
            SEARCH: begin
                bit_cnt_next = '0;
                if (is_comma) begin
                    bc_cnt_next = BC_W'(1);
                    if (LOCK_COUNT <= 1) begin
                        state_next  = LOCKED;
                        active_next = 1'b1;
                    end else begin
                        state_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_next = bit_cnt_wrap;
                if (byte_done) begin
                    if (is_comma) begin
                        bc_cnt_next = bc_cnt_inc;
                        if (bc_cnt_inc == LOCK_MAX) begin
                            state_next  = LOCKED;
                            active_next = 1'b1;
                        end
                    end else begin
                        bc_cnt_next  = '0;
                        bit_cnt_next = '0;
                        state_next   = SEARCH;
                    end
                end
            end
            LOCKED: begin
                bit_cnt_next = bit_cnt_wrap;
                // Idle commas keep the last data byte visible but mark it stale.
                if (byte_done) begin
                    strobe_next = 1'b1;
                    if (is_comma) begin
                        valid_next = 1'b0;
                    end else begin
                        valid_next = 1'b1;
                        data_next  = sr_next;
                    end
                end
            end
            default: begin
                state_next   = SEARCH;
                bit_cnt_next = '0;
                bc_cnt_next  = '0;
                valid_next   = 1'b0;
                active_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: comma lock, data delivery, idle
// commas while locked, offset alignment, broken comma runs and mid-byte reset.
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int   vectors     = 0;
    int   miscompares = 0;
    int   mid_strobes;
    logic pre_valid;

    serial_paralelo_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic sendBit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Shifts one symbol MSB first; records strobes seen before the boundary
    // and the valid flag just before the final bit.
    task automatic applyStimulus(input logic [7:0] sym);
        mid_strobes = 0;
        for (int i = 7; i >= 0; i--) begin
            sendBit(sym[i]);
            if (i == 1) pre_valid = valid_out;
            if (i != 0 && byte_strobe) mid_strobes++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        sendBit(1'b0);
        sendBit(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;

        // Reset with a toggling line
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("rst_data",   32'(data_out),    32'h00);
        checkOutput("rst_valid",  32'(valid_out),   32'h0);
        checkOutput("rst_strobe", 32'(byte_strobe), 32'h0);
        checkOutput("rst_active", 32'(active),      32'h0);
        reset = 1'b0;
        repeat (16) sendBit(1'b0);
        checkOutput("idle_active", 32'(active),    32'h0);
        checkOutput("idle_valid",  32'(valid_out), 32'h0);

        // Lock on four commas, then deliver EE, 01, FF
        repeat (3) applyStimulus(8'hBC);
        checkOutput("lock3_active", 32'(active), 32'h0);
        applyStimulus(8'hBC);
        checkOutput("lock4_active", 32'(active),    32'h1);
        checkOutput("lock4_valid",  32'(valid_out), 32'h0);
        applyStimulus(8'hEE);
        checkOutput("ee_data",     32'(data_out),    32'hEE);
        checkOutput("ee_valid",    32'(valid_out),   32'h1);
        checkOutput("ee_strobe",   32'(byte_strobe), 32'h1);
        checkOutput("ee_midstrb",  32'(mid_strobes), 32'h0);
        checkOutput("ee_prevalid", 32'(pre_valid),   32'h0);
        applyStimulus(8'h01);
        checkOutput("01_prevalid", 32'(pre_valid),   32'h1);
        checkOutput("01_midstrb",  32'(mid_strobes), 32'h0);
        checkOutput("01_data",     32'(data_out),    32'h01);
        checkOutput("01_strobe",   32'(byte_strobe), 32'h1);
        applyStimulus(8'hFF);
        checkOutput("ff_data",   32'(data_out),    32'hFF);
        checkOutput("ff_valid",  32'(valid_out),   32'h1);
        checkOutput("ff_strobe", 32'(byte_strobe), 32'h1);
        sendBit(1'b0);
        checkOutput("ff_pulse_end", 32'(byte_strobe), 32'h0);
        checkOutput("ff_hold",      32'(valid_out),   32'h1);
        repeat (7) sendBit(1'b0);
        checkOutput("00_data", 32'(data_out), 32'h00);

        // Idle comma between data bytes while locked
        applyStimulus(8'hAA);
        checkOutput("aa_valid",  32'(valid_out),   32'h1);
        checkOutput("aa_data",   32'(data_out),    32'hAA);
        checkOutput("aa_strobe", 32'(byte_strobe), 32'h1);
        applyStimulus(8'hBC);
        checkOutput("bc_valid",  32'(valid_out),   32'h0);
        checkOutput("bc_data",   32'(data_out),    32'hAA);
        checkOutput("bc_strobe", 32'(byte_strobe), 32'h1);
        checkOutput("bc_active", 32'(active),      32'h1);
        applyStimulus(8'hAB);
        checkOutput("ab_valid",  32'(valid_out),   32'h1);
        checkOutput("ab_data",   32'(data_out),    32'hAB);
        checkOutput("ab_strobe", 32'(byte_strobe), 32'h1);

        // Reset at bit 4 of a data byte, then relock from scratch
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        reset = 1'b1;
        sendBit(1'b0);
        checkOutput("midrst_data",   32'(data_out),    32'h00);
        checkOutput("midrst_valid",  32'(valid_out),   32'h0);
        checkOutput("midrst_strobe", 32'(byte_strobe), 32'h0);
        checkOutput("midrst_active", 32'(active),      32'h0);
        reset = 1'b0;
        repeat (3) applyStimulus(8'hBC);
        checkOutput("relock3_active", 32'(active), 32'h0);
        applyStimulus(8'hBC);
        checkOutput("relock4_active", 32'(active), 32'h1);

        // Alignment found after a 3-bit offset
        doReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        repeat (4) applyStimulus(8'hBC);
        checkOutput("off_active", 32'(active), 32'h1);
        applyStimulus(8'h55);
        checkOutput("off_data",  32'(data_out),  32'h55);
        checkOutput("off_valid", 32'(valid_out), 32'h1);

        // Broken comma run restarts the lock count
        doReset();
        repeat (3) applyStimulus(8'hBC);
        applyStimulus(8'h12);
        checkOutput("brk_active", 32'(active),    32'h0);
        checkOutput("brk_valid",  32'(valid_out), 32'h0);
        checkOutput("brk_data",   32'(data_out),  32'h00);
        repeat (3) applyStimulus(8'hBC);
        checkOutput("brk3_active", 32'(active), 32'h0);
        applyStimulus(8'hBC);
        checkOutput("brk4_active", 32'(active), 32'h1);
        applyStimulus(8'h34);
        checkOutput("brk_34_data",  32'(data_out),  32'h34);
        checkOutput("brk_34_valid", 32'(valid_out), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
